// File: rtl/inert_resp_pkg.sv
// Shared definitions for the Z-gyro SPI responder: register map, identity value
// and the frame-handling FSM states.
package inert_resp_pkg;

    localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
    localparam logic [6:0] ADDR_GYRO_CFG = 7'h11;
    localparam logic [6:0] ADDR_CTRL5    = 7'h14;
    localparam logic [6:0] ADDR_STATUS   = 7'h1E;
    localparam logic [6:0] ADDR_YAW_L    = 7'h26;
    localparam logic [6:0] ADDR_YAW_H    = 7'h27;

    localparam logic [7:0] WHO_AM_I_DEFAULT = 8'h6A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_COMMIT
    } spi_state_t;

endpackage

// File: rtl/spi_serf_sync.sv
// Two-flop synchronizer followed by an edge-detect flop for one SPI pin.
module spi_serf_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= pin;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
    assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/inert_sensor_resp.sv
// SPI responder standing in for the inertial sensor's Z-gyro: 16-bit command
// frames, config registers, periodic yaw sampling and a data-ready interrupt.
module inert_sensor_resp
    import inert_resp_pkg::*;
#(
    parameter int         SAMPLE_PERIOD = 16384,
    parameter logic [7:0] WHO_AM_I_VAL  = WHO_AM_I_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SS_n,
    input  logic                SCLK,
    input  logic                MOSI,
    output logic                MISO,
    output logic                INT,
    input  logic signed [15:0]  yaw_rt_in,
    output logic                init_done
);

    localparam int             CW   = $clog2(SAMPLE_PERIOD);
    localparam logic [CW-1:0]  LAST = CW'(SAMPLE_PERIOD - 1);

    logic ss_level_unused, ss_rise, ss_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_serf_sync u_sync_ss (
        .clk(clk), .rst(rst), .pin(SS_n),
        .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
    );
    spi_serf_sync u_sync_sclk (
        .clk(clk), .rst(rst), .pin(SCLK),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_serf_sync u_sync_mosi (
        .clk(clk), .rst(rst), .pin(MOSI),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t    state_reg, state_next;
    logic [4:0]    rise_cnt_reg;
    logic [15:0]   rx_reg;
    logic [7:0]    rd_byte_reg;
    logic          miso_reg;
    logic [7:0]    int_ctrl_reg, gyro_cfg_reg, ctrl5_reg;
    logic          ovr_reg, int_reg;
    logic [15:0]   sample_reg;
    logic [7:0]    shadow_reg;
    logic [2:0]    wr_seen_reg;
    logic [CW-1:0] cnt_reg;

    logic       shifting;
    logic [6:0] cmd_addr;
    logic [7:0] rd_mux;
    logic       commit, wr_en, rd_yaw_h, rd_status, wrap;

    assign shifting = (state_reg == ST_CMD || state_reg == ST_DATA) && sclk_rise && !ss_rise;
    // Address as it will stand once the 8th command bit has been shifted in.
    assign cmd_addr = {rx_reg[5:0], mosi_lvl};

    always_comb begin
        rd_mux = 8'h00;
        case (cmd_addr)
            ADDR_INT_CTRL: rd_mux = int_ctrl_reg;
            ADDR_WHO_AM_I: rd_mux = WHO_AM_I_VAL;
            ADDR_GYRO_CFG: rd_mux = gyro_cfg_reg;
            ADDR_CTRL5:    rd_mux = ctrl5_reg;
            ADDR_STATUS:   rd_mux = {7'd0, ovr_reg};
            ADDR_YAW_L:    rd_mux = shadow_reg;
            ADDR_YAW_H:    rd_mux = sample_reg[15:8];
            default:       rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (ss_fall) state_next = ST_CMD;
            ST_CMD: begin
                if (ss_rise)
                    state_next = ST_IDLE;
                else if (sclk_rise && rise_cnt_reg == 5'd7)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (ss_rise)
                    state_next = (rise_cnt_reg == 5'd16) ? ST_COMMIT : ST_IDLE;
                else if (sclk_rise && rise_cnt_reg == 5'd16)
                    state_next = ST_IDLE;   // a 17th rise spoils the frame
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_cnt_reg <= '0;
            rx_reg       <= '0;
            rd_byte_reg  <= '0;
            miso_reg     <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && ss_fall) begin
                rise_cnt_reg <= '0;
            end else if (shifting) begin
                rx_reg       <= {rx_reg[14:0], mosi_lvl};
                rise_cnt_reg <= rise_cnt_reg + 5'd1;
            end
            if (shifting && state_reg == ST_CMD && rise_cnt_reg == 5'd7)
                rd_byte_reg <= rx_reg[6] ? rd_mux : 8'h00;
            if (state_next != ST_DATA)
                miso_reg <= 1'b0;
            else if (state_reg == ST_DATA && sclk_fall)
                miso_reg <= rd_byte_reg[3'd7 - rise_cnt_reg[2:0]];
        end
    end

    assign commit    = (state_reg == ST_COMMIT);
    assign wr_en     = commit && !rx_reg[15];
    assign rd_yaw_h  = commit && rx_reg[15] && rx_reg[14:8] == ADDR_YAW_H;
    assign rd_status = commit && rx_reg[15] && rx_reg[14:8] == ADDR_STATUS;
    assign wrap      = int_ctrl_reg[1] && cnt_reg == LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_ctrl_reg <= '0;
            gyro_cfg_reg <= '0;
            ctrl5_reg    <= '0;
            wr_seen_reg  <= '0;
            cnt_reg      <= '0;
            sample_reg   <= '0;
            shadow_reg   <= '0;
            int_reg      <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (rx_reg[14:8])
                    ADDR_INT_CTRL: begin int_ctrl_reg <= rx_reg[7:0]; wr_seen_reg[0] <= 1'b1; end
                    ADDR_GYRO_CFG: begin gyro_cfg_reg <= rx_reg[7:0]; wr_seen_reg[1] <= 1'b1; end
                    ADDR_CTRL5:    begin ctrl5_reg    <= rx_reg[7:0]; wr_seen_reg[2] <= 1'b1; end
                    default: ;
                endcase
            end
            if (!int_ctrl_reg[1] || wrap) cnt_reg <= '0;
            else                          cnt_reg <= cnt_reg + 1'b1;
            if (wrap)     sample_reg <= yaw_rt_in;
            // Shadow captures the pre-wrap sample even when both land together.
            if (rd_yaw_h) shadow_reg <= sample_reg[7:0];
            if (wrap)          int_reg <= 1'b1;
            else if (rd_yaw_h) int_reg <= 1'b0;
            if (wrap && int_reg && !rd_yaw_h) ovr_reg <= 1'b1;
            else if (rd_status)               ovr_reg <= 1'b0;
        end
    end

    assign MISO      = miso_reg;
    assign INT       = int_reg;
    assign init_done = &wr_seen_reg;

endmodule

// File: doc/inert_sensor_resp.md
# inert_sensor_resp

Behavioural-synthesizable SPI responder that models the inertial sensor's Z-gyro interface, i.e. the serf end of the inertial interface's SPI monarch link. Accepts 16-bit command frames (write config registers, read yaw bytes), produces periodic yaw samples from an input bus, and raises INT when a fresh sample is ready. Used in the full-chip bench and on FPGA loopback in place of the physical sensor.

## Interface
- SAMPLE_PERIOD, 16384: clk cycles between yaw samples once INT is enabled (≥ 64).
- WHO_AM_I_VAL, 8'h6A: value returned from address 0x0F.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- SS_n  in  1  SPI select, active low
- SCLK  in  1  SPI clock, idles high; half-period ≥ 4 clk
- MOSI  in  1  command/data from monarch, MSB first
- MISO  out  1  read data to monarch
- INT  out  1  high while an unread sample is pending
- yaw_rt_in  in  16  signed yaw rate to be sampled
- init_done  out  1  high once regs 0x0D, 0x11, 0x14 have each been written since reset

## Operation
- SS_n, SCLK, MOSI each pass through 2 sync flops plus 1 edge-detect flop; all protocol logic runs on synchronized signals and detected edges.
- Frame: SS_n fall, 16 SCLK rises, SS_n rise. MOSI sampled on each SCLK rise into 16-bit rx shift; rise counter 0..16.
- Bit 15 = 1 read, 0 write; bits 14:8 address; bits 7:0 write data (ignored on reads).
- FSM: IDLE (SS_n high) -> CMD on SS_n fall (rises 1–8) -> DATA after rise 8 (rises 9–16) -> COMMIT on SS_n rise -> IDLE. SS_n rise from CMD/DATA with rise count ≠ 16: abort, no side effects.
- At rise 8: decode address, latch rd_byte. MISO = 0 outside DATA; at the SCLK fall following rise n (n = 8..15) MISO = rd_byte[15-n], held until next fall.
- Register map (reset 0): 0x0D INT_CTRL (bit1 = INT enable), 0x11 GYRO_CFG, 0x14 CTRL5 — write/readable; 0x0F WHO_AM_I; 0x1E STATUS (bit0 overrun, cleared by reading it); 0x27 yaw high; 0x26 yaw low shadow. Unmapped read -> 8'h00; unmapped write ignored.
- Writes take effect at COMMIT only.
- Sample counter runs only while INT_CTRL[1]=1, else held at 0. On wrap (SAMPLE_PERIOD-1 -> 0): sample <= yaw_rt_in, INT <= 1; if INT already 1, set overrun.
- Read of 0x27 returns sample[15:8]; its COMMIT copies sample[7:0] into low shadow and clears INT. Read of 0x26 returns the shadow, so H-then-L is coherent.

## Timing
- Reset: MISO=0, INT=0, init_done=0, all regs/sample/shadow 0, FSM IDLE, counter 0.
- Sync latency: 3 clk from pin edge to internal edge pulse.
- INT rises 1 clk after the wrap cycle; falls 1 clk after COMMIT of a 0x27 read.
- Sample wrap and 0x27 COMMIT in same cycle: shadow gets the old sample, new sample loaded, INT stays 1, no overrun.
- Clearing INT_CTRL[1] does not clear a pending INT.
- Reset mid-frame: frame discarded; next SS_n fall starts clean.

## Structure
- Package inert_resp_pkg: register address localparams, WHO_AM_I default, FSM state enum.
- Sub-module spi_serf_sync: 3-flop synchronizer/edge detector, instantiated for SS_n, SCLK, MOSI.

## Test plan
- Reset, read 0x0F (frame 16'h8F00) -> MISO byte 8'h6A, INT=0, init_done=0.
- Write 0x0D02, 0x1160, 0x1440 -> init_done=1; INT rises SAMPLE_PERIOD+1 clk after first write's COMMIT.
- yaw_rt_in=16'h1234, wait INT, frames 16'hA700 then 16'hA600 -> bytes 8'h12, 8'h34; INT falls after first frame.
- Change yaw_rt_in to 16'hABCD with a wrap between the H and L reads -> returns 8'h12 then 8'h34, INT high again.
- Two wraps without reading -> STATUS read returns 8'h01, second STATUS read returns 8'h00.
- Abort write 16'h1160 after 10 SCLK rises -> GYRO_CFG stays 8'h00, init_done unchanged.
